// File: rtl/axi_rd_slave.sv
// AXI-style read responder: accepts one read request at a time, splits it into aligned
// native burst commands and returns the data through a credit-managed FIFO.
module axi_rd_slave #(
    parameter int unsigned ADDR_WIDTH  = 27,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned BURST_BEATS = 4,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_end,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  rlast,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rd_cmd_valid,
    input  logic                  rd_cmd_ready,
    output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    input  logic                  rd_data_valid,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StCmd, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [8:0]            total_q;
    logic [8:0]            rnd_total_q;
    logic [8:0]            ncmd_q;
    logic [8:0]            issued_q;
    logic [8:0]            ret_cnt_q;
    logic [8:0]            pop_cnt_q;
    logic                  last_seen_q;
    logic [CW-1:0]         credits_q;
    logic [CW-1:0]         count_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic       busy;
    logic       ar_fire;
    logic       cmd_fire;
    logic       fifo_wr;
    logic       discard;
    logic       pop;
    logic       last_done;
    logic [8:0] total_d;
    logic [9:0] total_ext;
    logic [9:0] rnd_ext;

    always_comb begin
        busy         = (state_q != StIdle);
        arready      = (state_q == StIdle) && init_end && !rst;
        ar_fire      = arvalid && arready;
        rd_cmd_valid = (state_q == StCmd) && (credits_q >= CW'(BURST_BEATS));
        cmd_fire     = rd_cmd_valid && rd_cmd_ready;
        // Beats past the requested length are tail padding of the last burst.
        fifo_wr      = rd_data_valid && busy && (ret_cnt_q < total_q);
        discard      = rd_data_valid && busy && (ret_cnt_q >= total_q);
        rvalid       = (count_q != '0);
        pop          = rvalid && rready;
        rdata        = rvalid ? mem[rd_ptr_q] : '0;
        rlast        = rvalid && (pop_cnt_q == total_q - 9'd1);
        last_done    = last_seen_q || (pop && rlast);
        rd_cmd_addr  = cmd_addr_q;
        total_d      = 9'(arlen) + 9'd1;
        total_ext    = {1'b0, total_d} + 10'(BURST_BEATS - 1);
        rnd_ext      = total_ext & ~10'(BURST_BEATS - 1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ar_fire) state_d = StCmd;
            StCmd:   if (cmd_fire && (issued_q + 9'd1 == ncmd_q)) state_d = StDrain;
            StDrain: if (last_done && (ret_cnt_q == rnd_total_q)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_addr_q  <= '0;
            total_q     <= '0;
            rnd_total_q <= '0;
            ncmd_q      <= '0;
            issued_q    <= '0;
            ret_cnt_q   <= '0;
            pop_cnt_q   <= '0;
            last_seen_q <= 1'b0;
            credits_q   <= CW'(FIFO_DEPTH);
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ar_fire) begin
                cmd_addr_q  <= araddr & ~ADDR_WIDTH'(BURST_BEATS - 1);
                total_q     <= total_d;
                rnd_total_q <= 9'(rnd_ext);
                ncmd_q      <= 9'(rnd_ext / 10'(BURST_BEATS));
                issued_q    <= '0;
                ret_cnt_q   <= '0;
                pop_cnt_q   <= '0;
                last_seen_q <= 1'b0;
            end else begin
                if (cmd_fire) begin
                    cmd_addr_q <= cmd_addr_q + ADDR_WIDTH'(BURST_BEATS);
                    issued_q   <= issued_q + 9'd1;
                end
                if (rd_data_valid && busy) ret_cnt_q <= ret_cnt_q + 9'd1;
                if (pop) pop_cnt_q <= pop_cnt_q + 9'd1;
                if (pop && rlast) last_seen_q <= 1'b1;
            end
            // Credits, FIFO occupancy and in-flight beats always sum to FIFO_DEPTH.
            credits_q <= credits_q - (cmd_fire ? CW'(BURST_BEATS) : '0)
                         + CW'(pop) + CW'(discard);
            count_q   <= count_q + CW'(fifo_wr) - CW'(pop);
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr_q] <= rd_data;
    end

endmodule

// File: tb/tb_axi_rd_slave.sv
// Bench for axi_rd_slave: transaction-level model with per-cycle checking, directed scenarios
// with literal expectations, then randomized traffic.
module tb_axi_rd_slave;

    localparam int AW = 27;
    localparam int DW = 16;
    localparam int BB = 4;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_end;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          rvalid;
    logic          rready;
    logic          rlast;
    logic [DW-1:0] rdata;
    logic          rd_cmd_valid;
    logic          rd_cmd_ready;
    logic [AW-1:0] rd_cmd_addr;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    axi_rd_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_BEATS(BB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .init_end     (init_end),
        .arvalid      (arvalid),
        .arready      (arready),
        .araddr       (araddr),
        .arlen        (arlen),
        .rvalid       (rvalid),
        .rready       (rready),
        .rlast        (rlast),
        .rdata        (rdata),
        .rd_cmd_valid (rd_cmd_valid),
        .rd_cmd_ready (rd_cmd_ready),
        .rd_cmd_addr  (rd_cmd_addr),
        .rd_data_valid(rd_data_valid),
        .rd_data      (rd_data)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Transaction model state
    bit            m_active = 0;
    int            m_total, m_ncmd, m_issued, m_ret, m_pop, m_disc;
    logic [AW-1:0] m_base;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ret_data_q[$];
    int            ret_time_q[$];
    logic [AW-1:0] cmd_log[$];
    logic [DW-1:0] beat_log[$];
    bit            last_log[$];
    bit            fixed_data = 1;
    bit            data_gaps = 0;
    int            next_val = 1;
    int            rready_mode = 1;
    int            cmd_mode = 0;
    bit            p_rv = 0, p_rr = 0, p_rl = 0, p_cv = 0, p_cr = 0;
    logic [DW-1:0] p_rd;
    logic [AW-1:0] p_ca;

    // Everything sampled here takes effect at the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            m_active = 0;
            exp_q.delete();
            ret_data_q.delete();
            ret_time_q.delete();
            p_rv = 0;
            p_cv = 0;
        end else begin
            if (p_rv && !p_rr) begin
                chk("rvalid_hold", rvalid, 1);
                chk("rdata_hold", rdata, p_rd);
                chk("rlast_hold", rlast, p_rl);
            end
            if (p_cv && !p_cr) begin
                chk("cmd_valid_hold", rd_cmd_valid, 1);
                chk("cmd_addr_hold", rd_cmd_addr, p_ca);
            end
            if (arready) chk("arready_legal", int'(init_end && !m_active), 1);
            if (arvalid && arready) begin
                m_active = 1;
                m_total  = int'(arlen) + 1;
                m_ncmd   = (m_total + BB - 1) / BB;
                m_base   = araddr & ~AW'(BB - 1);
                m_issued = 0;
                m_ret    = 0;
                m_pop    = 0;
                m_disc   = 0;
                exp_q.delete();
            end
            if (rvalid) begin
                chk("rvalid_has_data", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("rdata", rdata, exp_q[0]);
                    chk("rlast", rlast, int'(m_pop == m_total - 1));
                    if (rready) begin
                        beat_log.push_back(rdata);
                        last_log.push_back(rlast);
                        void'(exp_q.pop_front());
                        m_pop++;
                    end
                end
            end else if (rlast) begin
                chk("rlast_without_rvalid", rlast, 0);
            end
            if (rd_data_valid) begin
                if (m_ret < m_total) exp_q.push_back(rd_data);
                else m_disc++;
                m_ret++;
            end
            if (rd_cmd_valid) begin
                chk("cmd_legal", int'(m_active && m_issued < m_ncmd), 1);
                if (rd_cmd_ready) begin
                    chk("cmd_addr", rd_cmd_addr, AW'(m_base + AW'(m_issued * BB)));
                    cmd_log.push_back(rd_cmd_addr);
                    m_issued++;
                    chk("credit_bound", int'(m_issued * BB - m_pop - m_disc <= FD), 1);
                    for (int i = 0; i < BB; i++) begin
                        ret_data_q.push_back(fixed_data ? DW'(next_val) : DW'($urandom));
                        ret_time_q.push_back(cyc + 1 + int'($urandom_range(0, 3)));
                        next_val++;
                    end
                end
            end
            if (m_active && m_pop == m_total && m_ret == m_ncmd * BB) m_active = 0;
            p_rv = rvalid;
            p_rr = rready;
            p_rl = rlast;
            p_rd = rdata;
            p_cv = rd_cmd_valid;
            p_cr = rd_cmd_ready;
            p_ca = rd_cmd_addr;
        end
    end

    // Scheduler stand-in: command ready pattern and in-order data return.
    initial begin
        int t;
        rd_cmd_ready  = 0;
        rd_data_valid = 0;
        rd_data       = '0;
        forever begin
            @(posedge clk);
            #1;
            case (cmd_mode)
                0:       rd_cmd_ready = 1'b1;
                1:       rd_cmd_ready = 1'($urandom_range(0, 1));
                default: rd_cmd_ready = !rd_cmd_ready;
            endcase
            if (ret_data_q.size() > 0 && ret_time_q[0] <= cyc &&
                (!data_gaps || $urandom_range(0, 3) != 0)) begin
                rd_data_valid = 1'b1;
                rd_data       = ret_data_q.pop_front();
                t             = ret_time_q.pop_front();
            end else begin
                rd_data_valid = 1'b0;
                rd_data       = DW'($urandom);
            end
        end
    end

    initial begin
        rready = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rready_mode)
                0:       rready = 1'b0;
                1:       rready = 1'b1;
                default: rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic clear_logs();
        cmd_log.delete();
        beat_log.delete();
        last_log.delete();
        next_val = 1;
    endtask

    task automatic start_req(input logic [AW-1:0] a, input int len);
        bit acc;
        acc = 0;
        @(posedge clk);
        #1;
        arvalid = 1'b1;
        araddr  = a;
        arlen   = 8'(len);
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            if (arready) acc = 1;
        end
        chk("accept_timeout", acc, 1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic finish_req(input int budget);
        int n;
        n = 0;
        while (m_active && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("complete_timeout", m_active, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_req(input logic [AW-1:0] a, input int len);
        start_req(a, len);
        finish_req(8000);
    endtask

    task automatic chk_beats(input string name, input int n);
        chk({name, "_count"}, beat_log.size(), n);
        for (int i = 0; i < beat_log.size() && i < n; i++) begin
            chk({name, "_data"}, beat_log[i], i + 1);
            chk({name, "_last"}, last_log[i], int'(i == n - 1));
        end
    endtask

    task automatic chk_cmds(input string name, input logic [AW-1:0] a0, input int n);
        chk({name, "_ncmd"}, cmd_log.size(), n);
        for (int i = 0; i < cmd_log.size() && i < n; i++)
            chk({name, "_addr"}, cmd_log[i], AW'(a0 + AW'(i * BB)));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arready"}, arready, 0);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rlast"}, rlast, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_cmd_valid"}, rd_cmd_valid, 0);
        chk({tag, "_cmd_addr"}, rd_cmd_addr, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        int len;
        rst = 1; init_end = 1; arvalid = 0; araddr = '0; arlen = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 0;

        // Aligned 4-beat request
        clear_logs();
        do_req(27'h40, 3);
        chk_cmds("t1", 27'h40, 1);
        chk_beats("t1", 4);
        chk("t1_arready_back", arready, 1);

        // Unaligned start, two bursts
        clear_logs();
        do_req(27'h43, 7);
        chk_cmds("t2", 27'h40, 2);
        chk_beats("t2", 8);

        // Tail beats 7 and 8 dropped
        clear_logs();
        do_req(27'h80, 5);
        chk_cmds("t3", 27'h80, 2);
        chk_beats("t3", 6);
        chk("t3_fifo_empty", rvalid, 0);

        // Credit stall with the master not accepting
        clear_logs();
        rready_mode = 0;
        start_req(27'h100, 15);
        repeat (60) @(negedge clk);
        chk("t4_stalled_ncmd", cmd_log.size(), 2);
        chk("t4_cmd_valid_low", rd_cmd_valid, 0);
        chk("t4_rvalid", rvalid, 1);
        rready_mode = 1;
        finish_req(2000);
        chk_cmds("t4", 27'h100, 4);
        chk_beats("t4", 16);

        // Address wrap
        clear_logs();
        do_req(27'h7FFFFFE, 11);
        chk_cmds("wrap", 27'h7FFFFFC, 3);
        chk_beats("wrap", 12);

        // No acceptance before initialisation completes
        clear_logs();
        @(posedge clk);
        #1;
        init_end = 0; arvalid = 1; araddr = 27'h200; arlen = 8'd0;
        repeat (20) begin
            @(negedge clk);
            chk("t5_arready_low", arready, 0);
        end
        chk("t5_no_cmd", cmd_log.size(), 0);
        @(posedge clk);
        #1 init_end = 1;
        @(negedge clk);
        chk("t5_arready_high", arready, 1);
        @(posedge clk);
        #1 arvalid = 0;
        finish_req(500);
        chk_cmds("t5", 27'h200, 1);
        chk_beats("t5", 1);

        // Reset in the middle of a command phase
        clear_logs();
        rready_mode = 0;
        start_req(27'h300, 15);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("t6");
        @(posedge clk);
        #1 rst = 0;
        rready_mode = 1;
        clear_logs();
        do_req(27'h500, 3);
        chk_cmds("t6", 27'h500, 1);
        chk_beats("t6", 4);

        // Alternating command ready
        clear_logs();
        cmd_mode = 2;
        do_req(27'h1000, 15);
        chk_cmds("t7", 27'h1000, 4);
        chk_beats("t7", 16);

        // Randomized traffic
        fixed_data = 0;
        data_gaps  = 1;
        rready_mode = 2;
        for (int k = 0; k < 25; k++) begin
            cmd_mode = (k % 2 == 0) ? 1 : 2;
            a   = AW'($urandom);
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 40));
            clear_logs();
            do_req(a, len);
            chk("rand_beats", beat_log.size(), len + 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
